// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline stages.
// Holds the reset PC, the bubble encoding and the fetch-stage state/action enums.
package mips_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        BOOT,
        RUN
    } if_state_t;

    typedef enum logic [1:0] {
        ACT_FETCH,
        ACT_STALL,
        ACT_FLUSH
    } if_action_t;

    // Instructions are word aligned; the low two address bits never reach the PC.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold and flush controls and asynchronous reset.
// Flush has priority over hold; a flushed register carries a bubble.
import mips_pkg::*;

module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc4_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc4_out,
    output logic        valid_out
);

    logic [31:0] instr_d, instr_q;
    logic [31:0] pc4_d, pc4_q;
    logic        valid_d, valid_q;

    always_comb begin
        instr_d = instr_in;
        pc4_d   = pc4_in;
        valid_d = 1'b1;
        if (flush) begin
            instr_d = NOP_INSTR;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (hold) begin
            instr_d = instr_q;
            pc4_d   = pc4_q;
            valid_d = valid_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_out = instr_q;
    assign pc4_out   = pc4_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, boot FSM and IF/ID register.
// Optional macro IF_PERF_CNT_EN adds fetch/stall/flush event counters.
import mips_pkg::*;

module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    logic [31:0] pc_d, pc_q;
    logic [31:0] pc_plus4;
    if_state_t   state_d, state_q;
    if_action_t  action;
    logic        unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign pc_plus4  = pc_q + 32'd4;
    assign imem_addr = pc_q;

    // Redirect outranks stall: whatever a stall would hold is wrong-path.
    always_comb begin
        action = ACT_FETCH;
        if (redirect_valid) begin
            action = ACT_FLUSH;
        end else if (stall) begin
            action = ACT_STALL;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = RUN;
        endcase
        case (action)
            ACT_FLUSH: pc_d = word_align(redirect_pc);
            ACT_STALL: pc_d = pc_q;
            default:   pc_d = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            state_q <= BOOT;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk       (clk),
        .rst       (reset),
        .hold      (action == ACT_STALL),
        .flush     (action == ACT_FLUSH),
        .instr_in  (imem_instr),
        .pc4_in    (pc_plus4),
        .instr_out (if_id_instr),
        .pc4_out   (if_id_pc4),
        .valid_out (if_id_valid)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_d, fetch_cnt_q;
    logic [31:0] stall_cnt_d, stall_cnt_q;
    logic [31:0] flush_cnt_d, flush_cnt_q;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        case (action)
            ACT_FLUSH: flush_cnt_d = flush_cnt_q + 32'd1;
            ACT_STALL: stall_cnt_d = stall_cnt_q + 32'd1;
            default:   fetch_cnt_d = fetch_cnt_q + 32'd1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: table-driven vectors with a scoreboard
// queue, plus hand-written reset/boot corner sequences.
`timescale 1ns/1ps
module tb_if_fetch_stage;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

    logic [31:0] rom [64];
    exp_t        sbq [$];
    vec_t        vecs [15];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_fetch = 0, m_stall = 0, m_flush = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_read(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'h0040_0000;
        if (off < 32'd256) return rom[off[7:2]];
        return 32'h0;
    endfunction

    assign imem_instr = rom_read(imem_addr);

    if_fetch_stage #(
        .RESET_PC  (32'h0040_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_id_instr    (if_id_instr),
        .if_id_pc4      (if_id_pc4),
        .if_id_valid    (if_id_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check32({tag, " imem_addr"}, imem_addr, e.addr);
        check32({tag, " if_id_instr"}, if_id_instr, e.instr);
        check32({tag, " if_id_pc4"}, if_id_pc4, e.pc4);
        check32({tag, " if_id_valid"}, {31'b0, if_id_valid}, {31'b0, e.valid});
    endtask

    task automatic check_perf(input string tag);
`ifdef IF_PERF_CNT_EN
        check32({tag, " perf_fetch"}, perf_fetch_cnt, m_fetch);
        check32({tag, " perf_stall"}, perf_stall_cnt, m_stall);
        check32({tag, " perf_flush"}, perf_flush_cnt, m_flush);
`else
        if (tag.len() == 0) $display("perf counters not built");
`endif
    endtask

    // Called at a negedge: drive, push expectation, take one edge, compare at next negedge.
    task automatic apply(input string tag, input logic s, input logic rv,
                         input logic [31:0] rpc, input exp_t e);
        exp_t got;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        sbq.push_back(e);
        if (rv) m_flush++;
        else if (s) m_stall++;
        else m_fetch++;
        @(posedge clk);
        @(negedge clk);
        if (sbq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            got = sbq.pop_front();
            check_outputs(tag, got);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] i,
                                input logic [31:0] p, input logic v);
        exp_t e;
        e.addr = a; e.instr = i; e.pc4 = p; e.valid = v;
        return e;
    endfunction

    task automatic hold_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_fetch = 0; m_stall = 0; m_flush = 0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'h2000_0000 | i;
        rom[0]  = 32'h2408_0000;
        rom[2]  = 32'h0010_2021;
        rom[4]  = 32'h0c10_0010;
        rom[16] = 32'h3c01_0010;

        vecs[0]  = '{1'b0, 1'b0, 32'h0,          32'h0040_0004, 32'h2408_0000, 32'h0040_0004, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,          32'h0040_0008, 32'h2000_0001, 32'h0040_0008, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,          32'h0040_0008, 32'h2000_0001, 32'h0040_0008, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,          32'h0040_0008, 32'h2000_0001, 32'h0040_0008, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,          32'h0040_0008, 32'h2000_0001, 32'h0040_0008, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,          32'h0040_000c, 32'h0010_2021, 32'h0040_000c, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,          32'h0040_0010, 32'h2000_0003, 32'h0040_0010, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,          32'h0040_0014, 32'h0c10_0010, 32'h0040_0014, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 32'h0040_0041,  32'h0040_0040, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,          32'h0040_0044, 32'h3c01_0010, 32'h0040_0044, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 32'h0040_00f4,  32'h0040_00f4, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'h0,          32'h0040_00f8, 32'h2000_003d, 32'h0040_00f8, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 32'hffff_ffff,  32'hffff_fffc, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 32'h0,          32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 32'h0,          32'h0000_0004, 32'h0000_0000, 32'h0000_0004, 1'b1};

        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        #12;
        check_outputs("reset", mk(32'h0040_0000, 32'h0, 32'h0, 1'b0));
        check32("reset rom word0", imem_instr, 32'h2408_0000);
        check_perf("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].stall, vecs[i].rv, vecs[i].rpc,
                  mk(vecs[i].addr, vecs[i].instr, vecs[i].pc4, vecs[i].valid));
            if (i == 10) check_perf("stall+redirect");
        end
        check_perf("after table");

        // Reset asserted between edges must clear state before the next edge.
        stall = 1'b0;
        redirect_valid = 1'b0;
        #2 reset = 1'b1;
        m_fetch = 0; m_stall = 0; m_flush = 0;
        #1;
        check_outputs("midreset", mk(32'h0040_0000, 32'h0, 32'h0, 1'b0));
        check_perf("midreset");
        @(negedge clk);
        reset = 1'b0;

        apply("boot_redirect", 1'b0, 1'b1, 32'h0040_0021, mk(32'h0040_0020, 32'h0, 32'h0, 1'b0));
        apply("after_boot_redirect", 1'b0, 1'b0, 32'h0, mk(32'h0040_0024, 32'h2000_0008, 32'h0040_0024, 1'b1));
        check_perf("boot_redirect");

        hold_reset();
        apply("boot_stall", 1'b1, 1'b0, 32'h0, mk(32'h0040_0000, 32'h0, 32'h0, 1'b0));
        apply("after_boot_stall", 1'b0, 1'b0, 32'h0, mk(32'h0040_0004, 32'h2408_0000, 32'h0040_0004, 1'b1));
        check_perf("boot_stall");

        if (sbq.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard leftover: got %0d entries expected 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
